// File: rtl/sp_ram_pkg.sv
// Shared definitions for the byte-enabled single-port RAM: mode encodings,
// clear-sweep state type and the lane-count helper.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    WM_NORMAL,
    WM_WRITETHROUGH,
    WM_READBEFOREWRITE,
    WM_INVALID
  } write_mode_e;

  typedef enum logic [1:0] {
    RM_NOREG,
    RM_OUTREG,
    RM_INVALID
  } reg_mode_e;

  typedef enum logic {
    CLR_SWEEP,
    CLR_READY
  } clr_state_e;

  localparam int MAX_DATA_WIDTH = 72;

  function automatic int nb_lanes(input int data_width, input int byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Raw storage: byte-lane masked write and a registered read that always
// returns the word as it was before the same-edge write.
module sp_ram_array import sp_ram_pkg::*; #(
  parameter  int DW = 18,
  parameter  int AW = 10,
  parameter  int BW = 9,
  localparam int NB = nb_lanes(DW, BW)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [NB-1:0] be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // NOTE: storage and its read register carry no reset so the array maps onto
  // block RAM; zero-fill is done by the clear sweep in the parent instead.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < DW; i++) begin
        if (be_i[i / BW]) mem_q[addr_i][i] <= wdata_i[i];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_be.sv
// Parametrised single-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register, chip select and a post-reset clear sweep.
module sp_ram_be import sp_ram_pkg::*; #(
  parameter  int         DATA_WIDTH     = 18,
  parameter  int         ADDR_WIDTH     = 10,
  parameter  int         BYTE_WIDTH     = 9,
  parameter  string      REGMODE        = "NOREG",
  parameter  string      WRITEMODE      = "NORMAL",
  parameter  logic [2:0] CSDECODE       = 3'b000,
  parameter  bit         CLEAR_ON_RESET = 1'b1,
  localparam int         NB             = nb_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  WE,
  input  logic [NB-1:0]         BE,
  input  logic [2:0]            CS,
  input  logic [ADDR_WIDTH-1:0] AD,
  input  logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  RDY
);

  localparam write_mode_e WMODE =
    (WRITEMODE == "NORMAL")          ? WM_NORMAL :
    (WRITEMODE == "WRITETHROUGH")    ? WM_WRITETHROUGH :
    (WRITEMODE == "READBEFOREWRITE") ? WM_READBEFOREWRITE : WM_INVALID;
  localparam reg_mode_e RMODE =
    (REGMODE == "NOREG")  ? RM_NOREG :
    (REGMODE == "OUTREG") ? RM_OUTREG : RM_INVALID;
  localparam clr_state_e RESET_STATE = CLEAR_ON_RESET ? CLR_SWEEP : CLR_READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  if (WMODE == WM_INVALID) begin : g_bad_writemode
    $error("sp_ram_be: illegal WRITEMODE %s", WRITEMODE);
  end
  if (RMODE == RM_INVALID) begin : g_bad_regmode
    $error("sp_ram_be: illegal REGMODE %s", REGMODE);
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH || DATA_WIDTH < 1) begin : g_bad_width
    $error("sp_ram_be: DATA_WIDTH %0d out of range", DATA_WIDTH);
  end
  if (BYTE_WIDTH > DATA_WIDTH || BYTE_WIDTH < 1) begin : g_bad_byte
    $error("sp_ram_be: BYTE_WIDTH %0d exceeds DATA_WIDTH", BYTE_WIDTH);
  end

  clr_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clearing;
  logic                    sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clearing = 1'b0;
    if (state_q == CLR_SWEEP) begin
      clearing = 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) state_d = CLR_READY;
    end
  end

  assign RDY = (state_q == CLR_READY);
  assign sel = CE & (CS == CSDECODE) & RDY;

  logic                  arr_we;
  logic [NB-1:0]         arr_be;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] raw;

  assign arr_we    = clearing | (sel & WE);
  assign arr_be    = clearing ? {NB{1'b1}} : BE;
  assign arr_addr  = clearing ? cnt_q : AD;
  assign arr_wdata = clearing ? '0 : DI;

  sp_ram_array #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .BW (BYTE_WIDTH)
  ) u_array (
    .clk_i   (CLK),
    .re_i    (sel),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (raw)
  );

  // The read latch is rebuilt one cycle after the access from the raw array
  // word, the captured write data and lane enables, or its own held value.
  logic                  load_d, merge_d;
  logic                  load_q, merge_q;
  logic [NB-1:0]         be_q;
  logic [DATA_WIDTH-1:0] di_q;
  logic [DATA_WIDTH-1:0] lat_q;
  logic [DATA_WIDTH-1:0] lat_val;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] merged;

  assign load_d  = sel & (~WE | (WMODE != WM_NORMAL));
  assign merge_d = sel & WE & (WMODE == WM_WRITETHROUGH);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) wmask[i] = be_q[i / BYTE_WIDTH];
  end

  assign merged  = (raw & ~wmask) | (di_q & wmask);
  assign lat_val = !load_q ? lat_q : (merge_q ? merged : raw);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      load_q  <= 1'b0;
      merge_q <= 1'b0;
      be_q    <= '0;
      di_q    <= '0;
      lat_q   <= '0;
    end else begin
      load_q  <= load_d;
      merge_q <= merge_d;
      if (sel) begin
        be_q <= BE;
        di_q <= DI;
      end
      lat_q <= lat_val;
    end
  end

  if (RMODE == RM_OUTREG) begin : g_outreg
    logic [DATA_WIDTH-1:0] out_q;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)    out_q <= '0;
      else if (CE) out_q <= lat_val;
    end
    assign DO = out_q;
  end else begin : g_noreg
    assign DO = lat_val;
  end

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench for sp_ram_be: several parameterisations share one stimulus
// stream and are compared against hand-computed values.
module tb_sp_ram_be;

  localparam int DW = 18;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    be = '0;
  logic [2:0]    cs = '0;
  logic [AW-1:0] ad = '0;
  logic [DW-1:0] di = '0;

  logic [DW-1:0] do_n, do_wt, do_rb, do_or, do_cs, do_nc;
  logic          rdy_n, rdy_wt, rdy_rb, rdy_or, rdy_cs, rdy_nc;

  int total = 0;
  int bad   = 0;
  int edges;
  bit dz;

  always #5 clk = ~clk;

  sp_ram_be u_n (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_n), .RDY(rdy_n));
  sp_ram_be #(.WRITEMODE("WRITETHROUGH")) u_wt (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_wt), .RDY(rdy_wt));
  sp_ram_be #(.WRITEMODE("READBEFOREWRITE")) u_rb (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_rb), .RDY(rdy_rb));
  sp_ram_be #(.REGMODE("OUTREG")) u_or (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_or), .RDY(rdy_or));
  sp_ram_be #(.CSDECODE(3'b101)) u_cs (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_cs), .RDY(rdy_cs));
  sp_ram_be #(.CLEAR_ON_RESET(1'b0)) u_nc (
    .CLK(clk), .RST(rst_n), .CE(ce), .WE(we), .BE(be), .CS(cs), .AD(ad), .DI(di),
    .DO(do_nc), .RDY(rdy_nc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic c, input logic w, input logic [1:0] b,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    ce = c; we = w; be = b; ad = a; di = d;
    tick();
  endtask

  // Runs until RDY rises or the edge budget expires; flags any nonzero DO.
  task automatic run_sweep(input int limit, output int n, output bit zero);
    n = 0;
    zero = 1'b1;
    while (!rdy_n && n < limit) begin
      tick();
      n++;
      if (do_n != '0 || do_wt != '0 || do_rb != '0 || do_or != '0) zero = 1'b0;
    end
  endtask

  initial begin
    // Keep a write to address 0 pending through reset and the whole sweep.
    ce = 1'b1; we = 1'b1; be = 2'b11; ad = '0; di = 18'h15555; cs = 3'b000;
    repeat (3) tick();
    check("rst_rdy", rdy_n, 0);
    check("rst_do", do_n, 0);
    check("rst_do_oreg", do_or, 0);
    check("rst_rdy_noclear", rdy_nc, 1);

    rst_n = 1'b1;
    run_sweep(1100, edges, dz);
    ce = 1'b0;
    check("clear_len", edges, 1024);
    check("clear_do_zero", dz, 1);
    check("clear_rdy_oreg", rdy_or, 1);

    acc(1, 0, 2'b00, 10'h3FF, 0);
    check("rd_3ff", do_n, 0);
    acc(1, 0, 2'b00, 10'h000, 0);
    check("sweep_write_ignored", do_n, 0);

    // Byte-lane write
    acc(1, 1, 2'b11, 5, 18'h3FFFF);
    acc(1, 1, 2'b01, 5, 18'h00000);
    check("rb_partial_old", do_rb, 18'h3FFFF);
    acc(1, 0, 2'b00, 5, 0);
    check("byte_write", do_n, 18'h3FE00);

    // Read-during-write modes
    acc(1, 1, 2'b11, 7, 18'h12345);
    acc(1, 0, 2'b00, 5, 0);
    acc(1, 1, 2'b11, 7, 18'h0ABCD);
    check("wm_normal", do_n, 18'h3FE00);
    check("wm_writethrough", do_wt, 18'h0ABCD);
    check("wm_readbefore", do_rb, 18'h12345);
    acc(1, 1, 2'b10, 7, 18'h3FFFF);
    check("wm_wt_partial", do_wt, 18'h3FFCD);
    check("wm_rb_partial", do_rb, 18'h0ABCD);
    check("wm_normal_hold", do_n, 18'h3FE00);
    acc(1, 0, 2'b00, 7, 0);
    check("rd_after_partial", do_n, 18'h3FFCD);

    // CE low blocks the access
    acc(0, 1, 2'b11, 5, 0);
    acc(1, 0, 2'b00, 5, 0);
    check("ce_low_no_write", do_n, 18'h3FE00);

    // Output register pipeline
    acc(1, 1, 2'b11, 1, 18'h11);
    acc(1, 1, 2'b11, 2, 18'h22);
    acc(1, 1, 2'b11, 3, 18'h33);
    acc(1, 0, 2'b00, 1, 0);
    check("oreg_latency", do_or, 18'h3FE00);
    check("noreg_rd1", do_n, 18'h11);
    acc(1, 0, 2'b00, 2, 0);
    check("oreg_a1", do_or, 18'h11);
    acc(1, 0, 2'b00, 3, 0);
    check("oreg_a2", do_or, 18'h22);
    acc(1, 0, 2'b00, 3, 0);
    check("oreg_a3", do_or, 18'h33);
    acc(1, 0, 2'b00, 1, 0);
    acc(1, 0, 2'b00, 2, 0);
    check("oreg_slip_a1", do_or, 18'h11);
    acc(0, 0, 2'b00, 3, 0);
    check("oreg_ce_hold", do_or, 18'h11);
    acc(1, 0, 2'b00, 3, 0);
    check("oreg_slip_a2", do_or, 18'h22);
    acc(1, 0, 2'b00, 3, 0);
    check("oreg_slip_a3", do_or, 18'h33);

    // Chip select
    cs = 3'b100;
    acc(1, 1, 2'b11, 9, 18'h2AAAA);
    cs = 3'b101;
    acc(1, 0, 2'b00, 9, 0);
    check("cs_miss_write", do_cs, 0);
    acc(1, 1, 2'b11, 9, 18'h15555);
    acc(1, 0, 2'b00, 9, 0);
    check("cs_hit_write", do_cs, 18'h15555);
    cs = 3'b000;
    acc(1, 0, 2'b00, 9, 0);
    check("cs_other_block", do_n, 0);

    // Asynchronous reset with data on DO, then reset in the middle of a sweep
    acc(1, 0, 2'b00, 7, 0);
    acc(1, 0, 2'b00, 7, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_do", do_n, 0);
    check("async_rst_do_oreg", do_or, 0);
    check("async_rst_rdy", rdy_n, 0);
    ce = 1'b1; we = 1'b1; be = 2'b11; ad = '0; di = 18'h15555;
    tick();
    tick();
    rst_n = 1'b1;
    run_sweep(300, edges, dz);
    check("mid_pre_rdy", rdy_n, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    run_sweep(1100, edges, dz);
    ce = 1'b0;
    check("mid_clear_len", edges, 1024);
    check("mid_clear_do_zero", dz, 1);
    acc(1, 0, 2'b00, 0, 0);
    check("mid_sweep_write_ignored", do_n, 0);
    acc(1, 0, 2'b00, 7, 0);
    check("mid_sweep_cleared", do_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
